// File: rtl/arb_mux_pkg.sv
// rtl/arb_mux_pkg.sv - shared types and helpers for arb_grant_mux
//
// Purpose: FSM state type and the one-hot check used to validate arbiter
// grants. The bench imports this package as well.
// Ports: none (package).
package arb_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_mux_state_t;

    // Widest vector is_onehot() accepts; narrower vectors are zero-extended.
    localparam int ONEHOT_MAX_W = 64;

    // True when exactly one bit is set. Clearing the lowest set bit of a
    // one-hot value leaves zero.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// rtl/onehot_to_bin.sv - one-hot to binary index decoder with legality flag
//
// Purpose: decodes the arbiter grant vector into a port index.
// Ports:
//   onehot       in   WIDTH  one-hot input vector
//   idx          out  IDX_W  binary index of the set bit (meaningful only when valid_onehot)
//   valid_onehot out  1      exactly one bit of onehot is set
module onehot_to_bin #(
    parameter int  WIDTH = 4,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             valid_onehot
);
    import arb_mux_pkg::*;

    // OR of the indices of all set bits; exact whenever the input is one-hot.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
    end

    assign valid_onehot = is_onehot(ONEHOT_MAX_W'(onehot));

endmodule

// File: rtl/arb_grant_mux.sv
// rtl/arb_grant_mux.sv - packet-locking grant consumer for the fixed-priority arbiter
//
// Purpose: presents per-port packet requests to the arbiter, latches the
// one-hot grant and forwards the winning port's packet to the single output
// channel, holding the lock until the last beat is accepted.
// Optional feature macro: ARB_MUX_BEAT_LIMIT_EN (forced release after MAX_BEATS beats).
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   in_valid_i    in   NUM_PORTS         per-port beat valid
//   in_data_i     in   NUM_PORTS*DATA_W  per-port beat data, port p at [p*DATA_W +: DATA_W]
//   in_last_i     in   NUM_PORTS         per-port last-beat flag
//   in_ready_o    out  NUM_PORTS         per-port beat accept (locked port only)
//   arb_req_o     out  NUM_PORTS         requests to the arbiter
//   arb_gnt_i     in   NUM_PORTS         one-hot grant from the arbiter
//   out_valid_o   out  1                 downstream beat valid
//   out_data_o    out  DATA_W            downstream beat data
//   out_last_o    out  1                 downstream last-beat flag
//   out_ready_i   in   1                 downstream accept
//   busy_o        out  1                 lock held
//   sel_o         out  SEL_W             locked port index
//   beat_cnt_o    out  CNT_W             beats accepted in the current packet
//   gnt_err_o     out  1                 pulse after an illegal grant
//   timeout_o     out  1                 pulse after a forced release
module arb_grant_mux #(
    parameter int  NUM_PORTS = 4,
    parameter int  DATA_W    = 8,
    parameter int  CNT_W     = 8,
    parameter int  MAX_BEATS = 16,
    localparam int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        in_valid_i,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data_i,
    input  logic [NUM_PORTS-1:0]        in_last_i,
    output logic [NUM_PORTS-1:0]        in_ready_o,
    output logic [NUM_PORTS-1:0]        arb_req_o,
    input  logic [NUM_PORTS-1:0]        arb_gnt_i,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic                        busy_o,
    output logic [SEL_W-1:0]            sel_o,
    output logic [CNT_W-1:0]            beat_cnt_o,
    output logic                        gnt_err_o,
    output logic                        timeout_o
);
    import arb_mux_pkg::*;

`ifdef ARB_MUX_BEAT_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MAX_BEATS - 1);

    arb_mux_state_t   state;
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] beat_cnt;
    logic             gnt_err_q;
    logic             timeout_q;

    logic [SEL_W-1:0] gnt_idx;
    logic             gnt_onehot;
    logic             gnt_ok;
    logic             locked;
    logic             real_last;
    logic             force_last;
    logic             xfer;

    onehot_to_bin #(
        .WIDTH (NUM_PORTS)
    ) u_gnt_dec (
        .onehot       (arb_gnt_i),
        .idx          (gnt_idx),
        .valid_onehot (gnt_onehot)
    );

    // Outputs are masked while reset is asserted so nothing leaks out of a
    // truncated packet in the reset cycle itself.
    assign locked     = (state == LOCKED) && !reset;
    assign real_last  = in_last_i[sel_q];
    assign force_last = LIMIT_EN && (beat_cnt == LIMIT_CNT);
    assign gnt_ok     = gnt_onehot && ((arb_gnt_i & in_valid_i) != '0);
    assign xfer       = out_valid_o && out_ready_i;

    always_comb begin
        in_ready_o = '0;
        if (locked) begin
            in_ready_o[sel_q] = out_ready_i;
        end
    end

    assign arb_req_o   = locked ? '0 : in_valid_i;
    assign out_valid_o = locked && in_valid_i[sel_q];
    assign out_data_o  = locked ? in_data_i[sel_q*DATA_W +: DATA_W] : '0;
    assign out_last_o  = locked && (real_last || force_last);
    assign busy_o      = locked;
    assign sel_o       = reset ? '0 : sel_q;
    assign beat_cnt_o  = reset ? '0 : beat_cnt;
    assign gnt_err_o   = gnt_err_q && !reset;
    assign timeout_o   = timeout_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel_q     <= '0;
            beat_cnt  <= '0;
            gnt_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            gnt_err_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        state    <= LOCKED;
                        sel_q    <= gnt_idx;
                        beat_cnt <= '0;
                    end else if (arb_gnt_i != '0) begin
                        gnt_err_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (out_last_o) begin
                            state     <= IDLE;
                            beat_cnt  <= '0;
                            // A forced release that cut a packet short.
                            timeout_q <= force_last && !real_last;
                        end else if (beat_cnt != '1) begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_grant_mux.sv
// tb/tb_arb_grant_mux.sv - scoreboard bench for arb_grant_mux
module tb_arb_grant_mux;
    import arb_mux_pkg::*;

    localparam int NP = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int MB = 4;
    localparam int SW = $clog2(NP);
`ifdef ARB_MUX_BEAT_LIMIT_EN
    localparam int LIMIT = MB;
`else
    localparam int LIMIT = 1 << 30;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   in_valid_i;
    logic [NP*DW-1:0] in_data_i;
    logic [NP-1:0]   in_last_i;
    logic [NP-1:0]   in_ready_o;
    logic [NP-1:0]   arb_req_o;
    logic [NP-1:0]   arb_gnt_i;
    logic            out_valid_o;
    logic [DW-1:0]   out_data_o;
    logic            out_last_o;
    logic            out_ready_i;
    logic            busy_o;
    logic [SW-1:0]   sel_o;
    logic [CW-1:0]   beat_cnt_o;
    logic            gnt_err_o;
    logic            timeout_o;

    always #5 clk = ~clk;

    arb_grant_mux #(
        .NUM_PORTS (NP),
        .DATA_W    (DW),
        .CNT_W     (CW),
        .MAX_BEATS (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .arb_req_o   (arb_req_o),
        .arb_gnt_i   (arb_gnt_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .sel_o       (sel_o),
        .beat_cnt_o  (beat_cnt_o),
        .gnt_err_o   (gnt_err_o),
        .timeout_o   (timeout_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [SW-1:0] port;
        logic [CW-1:0] idx;
        logic          tmo;
    } exp_t;

    beat_t drv_q[NP][$];   // beats each source still has to hand over
    beat_t mdl_q[NP][$];   // same packets, consumed by the model at grant time
    exp_t  exp_q[$];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit mon_en   = 1'b0;
    bit err_issue = 1'b0;
    bit err_prev  = 1'b0;
    bit tmo_prev  = 1'b0;

    bit m_locked = 1'b0;
    int m_port   = 0;
    int m_rem    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        chk_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid_o), 0);
        check({tag, "_out_data"},  32'(out_data_o), 0);
        check({tag, "_out_last"},  32'(out_last_o), 0);
        check({tag, "_in_ready"},  32'(in_ready_o), 0);
        check({tag, "_busy"},      32'(busy_o), 0);
        check({tag, "_sel"},       32'(sel_o), 0);
        check({tag, "_beat_cnt"},  32'(beat_cnt_o), 0);
        check({tag, "_gnt_err"},   32'(gnt_err_o), 0);
        check({tag, "_timeout"},   32'(timeout_o), 0);
        check({tag, "_arb_req"},   32'(arb_req_o), 32'(in_valid_i));
    endtask

    // Monitor: pops one expectation per accepted output beat; the error and
    // timeout pulses are due one cycle after the event that causes them.
    exp_t e;
    always @(negedge clk) begin
        if (mon_en) begin
            check("gnt_err", 32'(gnt_err_o), 32'(err_prev));
            err_prev = err_issue;
            check("timeout", 32'(timeout_o), 32'(tmo_prev));
            tmo_prev = 1'b0;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data_o), 32'(e.data));
                    check("out_last", 32'(out_last_o), 32'(e.last));
                    check("beat_sel", 32'(sel_o), 32'(e.port));
                    check("beat_cnt", 32'(beat_cnt_o), 32'(e.idx));
                    tmo_prev = e.tmo;
                end
            end
        end
    end

    function automatic bit all_done();
        for (int p = 0; p < NP; p++) if (drv_q[p].size() != 0) return 1'b0;
        return !m_locked;
    endfunction

    initial begin
        beat_t         b;
        exp_t          ne;
        logic [NP-1:0] g;
        logic [NP-1:0] er;
        int            r;
        int            n;
        int            len;
        int            p;
        int            cyc;

        reset       = 1'b1;
        in_valid_i  = '0;
        in_data_i   = '0;
        in_last_i   = '0;
        arb_gnt_i   = '0;
        out_ready_i = 1'b0;

        for (int q = 0; q < NP; q++) begin
            for (int k = 0; k < 6; k++) begin
                len = (q == 0 && k == 0) ? 6 : (q == 2 && k == 0) ? 3 : int'($urandom_range(1, 6));
                for (int i = 0; i < len; i++) begin
                    b.data = (q == 2 && k == 0) ? DW'(8'hA1 + i) : DW'($urandom);
                    b.last = (i == len - 1);
                    drv_q[q].push_back(b);
                    mdl_q[q].push_back(b);
                end
            end
        end

        // Reset state, then the first cycle with reset released.
        repeat (2) begin
            tick();
            in_valid_i = NP'($urandom);
            #1;
            idle_checks("rst");
        end
        reset = 1'b0;
        in_valid_i = '0;
        #1;
        idle_checks("post_rst");

        err_prev = 1'b0;
        tmo_prev = 1'b0;
        mon_en   = 1'b1;

        cyc = 0;
        while (!all_done() && cyc < 5000) begin
            tick();
            cyc++;
            for (int q = 0; q < NP; q++) begin
                if (drv_q[q].size() > 0 && $urandom_range(0, 4) != 0) begin
                    in_valid_i[q] = 1'b1;
                    in_data_i[q*DW +: DW] = drv_q[q][0].data;
                    in_last_i[q] = drv_q[q][0].last;
                end else begin
                    in_valid_i[q] = 1'b0;
                    in_data_i[q*DW +: DW] = DW'($urandom);
                    in_last_i[q] = 1'($urandom);
                end
            end
            out_ready_i = ($urandom_range(0, 3) != 0);
            arb_gnt_i = '0;
            #1;
            check("arb_req", 32'(arb_req_o), m_locked ? 0 : 32'(in_valid_i));
            er = '0;
            if (m_locked) er[m_port] = out_ready_i;
            check("in_ready", 32'(in_ready_o), 32'(er));
            check("busy", 32'(busy_o), 32'(m_locked));
            if (m_locked) check("sel", 32'(sel_o), 32'(m_port));

            g = '0;
            err_issue = 1'b0;
            if (!m_locked) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) begin
                    p = int'($urandom_range(0, NP - 1));
                    n = (p + 1 + int'($urandom_range(0, NP - 2))) % NP;
                    g[p] = 1'b1;
                    g[n] = 1'b1;
                    err_issue = 1'b1;
                end else if (r == 1 && in_valid_i != '1) begin
                    do p = int'($urandom_range(0, NP - 1)); while (in_valid_i[p]);
                    g[p] = 1'b1;
                    err_issue = 1'b1;
                end else if (r >= 4) begin
                    for (int q = NP - 1; q >= 0; q--) if (in_valid_i[q]) g = NP'(1) << q;
                end
            end
            arb_gnt_i = g;
            #1;

            if (m_locked) begin
                if (in_valid_i[m_port] && out_ready_i) begin
                    drv_q[m_port].delete(0);
                    m_rem--;
                    if (m_rem == 0) m_locked = 1'b0;
                end
            end else if (g != '0 && !err_issue) begin
                for (int q = 0; q < NP; q++) if (g[q]) p = q;
                m_locked = 1'b1;
                m_port   = p;
                n        = 0;
                ne.last  = 1'b0;
                while (!ne.last) begin
                    b = mdl_q[p].pop_front();
                    n++;
                    ne.data = b.data;
                    ne.last = b.last || (n == LIMIT);
                    ne.port = SW'(p);
                    ne.idx  = CW'(n - 1);
                    ne.tmo  = (n == LIMIT) && !b.last;
                    exp_q.push_back(ne);
                end
                m_rem = n;
            end
        end
        check("drain_in_budget", 32'(all_done()), 1);

        tick();
        in_valid_i = '0;
        arb_gnt_i  = '0;
        err_issue  = 1'b0;
        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        mon_en = 1'b0;

        // Illegal grants: two-hot, and one-hot on a port that is not valid.
        in_valid_i = 4'b0110;
        arb_gnt_i  = 4'b0110;
        tick();
        arb_gnt_i = '0;
        #1;
        check("twohot_err", 32'(gnt_err_o), 1);
        check("twohot_busy", 32'(busy_o), 0);
        in_valid_i = 4'b0111;
        arb_gnt_i  = 4'b1000;
        tick();
        arb_gnt_i = '0;
        #1;
        check("novalid_err", 32'(gnt_err_o), 1);
        check("novalid_busy", 32'(busy_o), 0);
        tick();
        check("err_one_pulse", 32'(gnt_err_o), 0);

        // Reset during beat 2 of a 4-beat packet.
        out_ready_i = 1'b1;
        in_valid_i  = 4'b0010;
        in_data_i   = '0;
        in_data_i[1*DW +: DW] = 8'h11;
        in_last_i   = '0;
        #1;
        arb_gnt_i = 4'b0010;
        tick();
        arb_gnt_i = '0;
        #1;
        check("rp_busy", 32'(busy_o), 1);
        check("rp_beat1", 32'(out_data_o), 32'h11);
        check("rp_cnt0", 32'(beat_cnt_o), 0);
        tick();
        in_data_i[1*DW +: DW] = 8'h12;
        #1;
        check("rp_cnt1", 32'(beat_cnt_o), 1);
        reset = 1'b1;
        #1;
        check("rp_in_reset_valid", 32'(out_valid_o), 0);
        tick();
        reset = 1'b0;
        in_valid_i = '0;
        #1;
        idle_checks("rp_after");
        in_valid_i = 4'b0001;
        in_data_i[0 +: DW] = 8'h55;
        in_last_i = 4'b0001;
        #1;
        arb_gnt_i = 4'b0001;
        tick();
        arb_gnt_i = '0;
        #1;
        check("new_busy", 32'(busy_o), 1);
        check("new_cnt", 32'(beat_cnt_o), 0);
        check("new_data", 32'(out_data_o), 32'h55);
        check("new_last", 32'(out_last_o), 1);
        check("new_sel", 32'(sel_o), 0);
        tick();
        check("new_release", 32'(busy_o), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/arb_grant_mux.md
# arb_grant_mux

Packet-locking grant consumer for the fixed-priority arbiter. It collects per-port packet requests and presents them to the arbiter. It latches the one-hot grant, then forwards the winning port's multi-beat packet to one downstream valid/ready channel, holding the lock until the last beat is accepted. This keeps packets from different ports from interleaving on the shared output.

## Interface
- NUM_PORTS, 4: number of requesting ports (≥2).
- DATA_W, 8: beat payload width.
- CNT_W, 8: beat counter width.
- MAX_BEATS, 16: forced-release beat limit; used only with ARB_MUX_BEAT_LIMIT_EN; 1 ≤ MAX_BEATS < 2^CNT_W.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid_i  input  NUM_PORTS  per-port beat valid.
- in_data_i  input  NUM_PORTS*DATA_W  per-port beat data; port p occupies bits [p*DATA_W +: DATA_W].
- in_last_i  input  NUM_PORTS  per-port last-beat flag.
- in_ready_o  output  NUM_PORTS  per-port beat accept.
- arb_req_o  output  NUM_PORTS  requests to the arbiter.
- arb_gnt_i  input  NUM_PORTS  one-hot grant from the arbiter (combinational from arb_req_o).
- out_valid_o  output  1  downstream beat valid.
- out_data_o  output  DATA_W  downstream beat data.
- out_last_o  output  1  downstream last-beat flag.
- out_ready_i  input  1  downstream accept.
- busy_o  output  1  high in LOCKED.
- sel_o  output  $clog2(NUM_PORTS)  locked port index.
- beat_cnt_o  output  CNT_W  beats accepted in the current packet.
- gnt_err_o  output  1  one-cycle pulse on an illegal grant.
- timeout_o  output  1  one-cycle pulse on a forced release (macro only; tied 0 otherwise).

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - arb_req_o = in_valid_i.
  - out_valid_o = 0; in_ready_o = 0.
  - If arb_gnt_i is exactly one-hot and the granted bit also has in_valid_i set: register sel_q = index, clear beat_cnt, go to LOCKED.
  - If arb_gnt_i is nonzero but not one-hot, or the granted port is not valid: stay in IDLE and pulse gnt_err_o in the next cycle.
  - arb_gnt_i = 0: stay in IDLE, no error.
- LOCKED:
  - arb_req_o = 0.
  - out_valid_o = in_valid_i[sel_q]; out_data_o = data slice of sel_q; out_last_o = in_last_i[sel_q].
  - in_ready_o[sel_q] = out_ready_i; all other in_ready_o bits are 0.
  - A beat transfers when out_valid_o && out_ready_i; each transfer increments beat_cnt, saturating at 2^CNT_W-1.
  - A transfer with out_last_o = 1 returns the FSM to IDLE and clears beat_cnt.
- Non-locked ports never see in_ready_o high. Their valid and data are ignored and are allowed to change freely.
- The locked port deasserting in_valid_i mid-packet is a bubble: the lock is held and out_valid_o = 0.
- Outside LOCKED, out_data_o and out_last_o are driven 0.
- sel_o = sel_q, beat_cnt_o = beat_cnt, busy_o = (state == LOCKED).

## Timing
- Reset: state = IDLE, sel_q = 0, beat_cnt = 0, gnt_err and timeout flags = 0.
- Every output evaluates to 0 during reset and in the cycle after reset deasserts, except arb_req_o, which equals in_valid_i.
- Grant to first beat: grant sampled in cycle N; LOCKED and out_valid_o is visible in cycle N+1.
- The data path is combinational from in_* to out_* while LOCKED; there is no added beat latency.
- Last beat accepted in cycle M: IDLE in M+1 (re-arbitration), next LOCKED in M+2. The inter-packet gap is one cycle minimum.
- A single-beat packet occupies LOCKED for one cycle if out_ready_i is high.
- Reset mid-packet: IDLE next cycle. The packet is truncated and no further beats are output; the source is responsible for discarding its remainder.
- Simultaneous requests are resolved by the arbiter only; this block takes whatever legal grant it receives.

## Configuration
- ARB_MUX_BEAT_LIMIT_EN defined:
  - When beat_cnt == MAX_BEATS-1, out_last_o is forced to 1.
  - Acceptance of that beat releases the lock to IDLE.
  - If in_last_i[sel_q] was 0 on that beat, timeout_o pulses for one cycle in the next cycle.
  - This bounds lock time for a stuck or oversized packet.
- ARB_MUX_BEAT_LIMIT_EN undefined:
  - No forced release; the lock is held until a real last beat.
  - MAX_BEATS is unused; timeout_o = 0.

## Structure
- Shared package arb_mux_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_mux_state_t.
  - Function is_onehot(), used for grant checking and shared with bench assertions.
- Sub-module onehot_to_bin (parameter WIDTH): one-hot grant in; binary index plus a valid_onehot flag out. It is instantiated once for the grant decode.

## Test plan
- Single port, 3-beat packet: port 2 valid with data 0xA1/0xA2/0xA3, last on beat 3, out_ready_i = 1, grant 4'b0100 → LOCKED one cycle later; out_data_o shows 0xA1, 0xA2, 0xA3 on consecutive cycles; IDLE after 0xA3; beat_cnt_o shows 0, 1, 2.
- Contention: ports 0 and 3 valid, arbiter grants 4'b0001 → port 3 in_ready_o stays 0 for all of port 0's packet; port 3 is granted in the re-arbitration cycle after port 0's last beat, with exactly one idle gap.
- Backpressure and bubble:
  - out_ready_i low for 4 cycles mid-packet → out_data_o is held stable and beat_cnt does not advance.
  - Locked port valid dropped for 2 cycles → out_valid_o = 0 and sel_o is unchanged.
- Illegal grant: arb_gnt_i = 4'b0110, or 4'b1000 while in_valid_i[3] = 0 → stays IDLE; gnt_err_o pulses once; busy_o = 0.
- Reset during beat 2 of 4 → all outputs 0 the next cycle; after reset a new grant starts cleanly with beat_cnt_o = 0.
- With ARB_MUX_BEAT_LIMIT_EN and MAX_BEATS = 4, 6-beat packet → out_last_o is forced on beat 4; the lock releases and timeout_o pulses once. Without the macro, all 6 beats pass and timeout_o stays 0.
